pool_window_seq: RTL
====================

# pool_window_seq

Window sequencer that sits directly upstream of `max_reg` in the pooling stage. On `start`, it walks a stored Q8.8 feature map in POOLxPOOL window order and reads each element from a synchronous feature-map RAM. It streams the elements into `max_reg` with a per-window clear, then emits one pooled value per window on a valid/ready output. Its output feeds the flatten/FC stage.

## Interface
Parameters:
- DATA_W, 16, sample width (signed Q8.8)
- IMG_W, 28, input map width in elements
- IMG_H, 28, input map height in elements
- POOL, 2, window edge (stride = POOL)
- ADDR_W, 10, feature-map RAM address width
- OADDR_W, 8, pooled-output index width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; accepted only in IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output accepted
- fmap_rd_en  out  1  RAM read strobe
- fmap_addr  out  ADDR_W  RAM read address
- fmap_rdata  in  DATA_W  RAM data, valid the cycle after fmap_rd_en
- mr_clear  out  1  active-high clear to max_reg `reset`
- mr_din  out  DATA_W  to max_reg `din` (= fmap_rdata)
- mr_valid  out  1  to max_reg `valid`
- mr_max  in  DATA_W  from max_reg `max_out`
- out_valid  out  1  pooled result valid
- out_ready  in  1  consumer accept
- out_data  out  DATA_W  pooled max (= mr_max while out_valid)
- out_addr  out  OADDR_W  raster index of pooled element

## Operation
- FSM states:
  - IDLE: start → CLEAR.
  - CLEAR: 1 cycle, mr_clear=1, then READ.
  - READ: POOL² cycles, fmap_rd_en=1, then DRAIN.
  - DRAIN: 1 cycle, then EMIT.
  - EMIT: wait for out_ready. If last window → FIN, else → CLEAR.
  - FIN: done=1, then IDLE.
- Counters:
  - pr: 0..IMG_H/POOL−1 (outer).
  - pc: 0..IMG_W/POOL−1.
  - dr, dc: 0..POOL−1, with dc fastest.
- fmap_addr = (pr·POOL+dr)·IMG_W + pc·POOL + dc. Width check: IMG_W·IMG_H ≤ 2^ADDR_W.
- mr_valid is fmap_rd_en registered by one cycle. mr_din is a combinational pass-through of fmap_rdata.
- out_addr = pr·(IMG_W/POOL) + pc. Output order is raster.
- No arithmetic on data; values pass through bit-exact as signed Q8.8.
- Elaboration error if IMG_W or IMG_H is not a multiple of POOL.
- start while busy: ignored.
- Reset at any point:
  - FSM → IDLE, counters 0.
  - All outputs 0 immediately (asynchronous).
  - An interrupted frame is discarded and requires a fresh start.

## Timing
- Reset values: busy=0, done=0, fmap_rd_en=0, fmap_addr=0, mr_clear=0, mr_valid=0, out_valid=0, out_addr=0. out_data follows mr_max but is meaningful only with out_valid.
- Per-window schedule (cycle 0 = CLEAR):
  - Cycles 1..POOL²: reads issued.
  - Cycles 2..POOL²+1: mr_valid high.
  - Cycle POOL²+2: EMIT, with out_valid and max_reg final.
- Window period with out_ready held high: POOL²+3 cycles (7 for POOL=2).
- Frame time: (IMG_W/POOL)(IMG_H/POOL)(POOL²+3)+1 cycles from start to done.
- Backpressure:
  - out_valid, out_data and out_addr stay stable until the cycle where out_valid & out_ready.
  - No reads are issued and max_reg is not cleared while stalled.
- busy rises the cycle after start and falls with done.

## Structure
- Shared package `cnn_pkg`:
  - DATA_W and Q_FRAC=8 constants.
  - Q8.8 sample typedef.
  - Pool FSM state enum (IDLE, CLEAR, READ, DRAIN, EMIT, FIN).
- One sub-module, `pool_addr_gen`:
  - pr/pc/dr/dc counters.
  - fmap_addr and out_addr generation.
  - Last-element and last-window flags.
  - Advances on FSM enables.
- The FSM and mr_valid pipeline register live in the top.

## Test plan
Use IMG_W=IMG_H=4, POOL=2 with a behavioural sync RAM and a real `max_reg` instance unless noted.
- Ramp map, elem[i]=i·256, out_ready=1 → out_data 1280, 1792, 3328, 3840 at out_addr 0..3. done once, 29 cycles after start.
- Address trace → window 0 reads 0,1,4,5; window 1 reads 2,3,6,7; window 3 reads 10,11,14,15. mr_valid lags fmap_rd_en by exactly 1 cycle.
- All-negative map (elem = −(i+1)·256) → outputs −256, −768, −2304, −2816. Confirms the clear prevents stale maxima.
- out_ready low 5 cycles on first result → out_valid held, out_data=1280 and out_addr=0 stable, no fmap_rd_en or mr_clear during the stall, remaining sequence unchanged.
- start re-pulsed mid-frame → ignored, no extra outputs, single done.
- reset_n low during window 2 READ → all outputs 0 asynchronously. After release and a new start, the full correct 4-output sequence is produced.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: Q8.8 sample format and pooling-sequencer state encoding.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 8;

  typedef logic signed [DATA_W-1:0] q88_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    EMIT  = 3'd4,
    FIN   = 3'd5
  } pool_state_e;

endpackage

// File: rtl/pool_addr_gen.sv
// Window/element counters for the pooling sequencer; produces the feature-map read
// address, the raster index of the pooled output, and the end-of-window/frame flags.
module pool_addr_gen #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int POOL    = 2,
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_elem_adv,
  input  logic               i_win_adv,
  output logic [ADDR_W-1:0]  o_fmap_addr,
  output logic [OADDR_W-1:0] o_out_addr,
  output logic               o_last_elem,
  output logic               o_last_win
);

  localparam int PW   = IMG_W / POOL;
  localparam int PH   = IMG_H / POOL;
  localparam int DC_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int PC_W = (PW > 1) ? $clog2(PW) : 1;
  localparam int PR_W = (PH > 1) ? $clog2(PH) : 1;

  localparam logic [ADDR_W-1:0]  L_POOL_A = ADDR_W'(POOL);
  localparam logic [ADDR_W-1:0]  L_IMGW_A = ADDR_W'(IMG_W);
  localparam logic [OADDR_W-1:0] L_PW_O   = OADDR_W'(PW);

  generate
    if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_pool
      $error("pool_addr_gen: IMG_W and IMG_H must be multiples of POOL");
    end
    if ((IMG_W * IMG_H) > (2 ** ADDR_W)) begin : g_bad_addr
      $error("pool_addr_gen: feature map does not fit in ADDR_W");
    end
    if ((PW * PH) > (2 ** OADDR_W)) begin : g_bad_oaddr
      $error("pool_addr_gen: pooled map does not fit in OADDR_W");
    end
  endgenerate

  logic [DC_W-1:0] r_dc;
  logic [DC_W-1:0] r_dr;
  logic [PC_W-1:0] r_pc;
  logic [PR_W-1:0] r_pr;

  assign o_last_elem = (r_dr == DC_W'(POOL - 1)) && (r_dc == DC_W'(POOL - 1));
  assign o_last_win  = (r_pr == PR_W'(PH - 1)) && (r_pc == PC_W'(PW - 1));

  assign o_fmap_addr = (ADDR_W'(r_pr) * L_POOL_A + ADDR_W'(r_dr)) * L_IMGW_A
                     + ADDR_W'(r_pc) * L_POOL_A + ADDR_W'(r_dc);
  assign o_out_addr  = OADDR_W'(r_pr) * L_PW_O + OADDR_W'(r_pc);

  // In-window counters step once per read; window counters step on each accepted output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dc <= '0;
      r_dr <= '0;
      r_pc <= '0;
      r_pr <= '0;
    end else begin
      if (i_elem_adv) begin
        if (r_dc == DC_W'(POOL - 1)) begin
          r_dc <= '0;
          if (r_dr == DC_W'(POOL - 1)) begin
            r_dr <= '0;
          end else begin
            r_dr <= r_dr + 1'b1;
          end
        end else begin
          r_dc <= r_dc + 1'b1;
        end
      end
      if (i_win_adv) begin
        if (r_pc == PC_W'(PW - 1)) begin
          r_pc <= '0;
          if (r_pr == PR_W'(PH - 1)) begin
            r_pr <= '0;
          end else begin
            r_pr <= r_pr + 1'b1;
          end
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pool_window_seq.sv
// Pooling window sequencer: reads each POOLxPOOL window from feature-map RAM into an
// external max_reg and emits one pooled value per window on a valid/ready output.
module pool_window_seq
  import cnn_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int POOL    = 2,
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               fmap_rd_en,
  output logic [ADDR_W-1:0]  fmap_addr,
  input  logic [DATA_W-1:0]  fmap_rdata,
  output logic               mr_clear,
  output logic [DATA_W-1:0]  mr_din,
  output logic               mr_valid,
  input  logic [DATA_W-1:0]  mr_max,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [OADDR_W-1:0] out_addr
);

  pool_state_e r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_rd_en;
  logic        r_mr_clear;
  logic        r_mr_valid;
  logic        r_out_valid;

  logic        w_elem_adv;
  logic        w_win_adv;
  logic        w_last_elem;
  logic        w_last_win;

  assign w_elem_adv = (r_state == READ);
  assign w_win_adv  = (r_state == EMIT) && out_ready;

  pool_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .POOL    (POOL),
    .ADDR_W  (ADDR_W),
    .OADDR_W (OADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_elem_adv  (w_elem_adv),
    .i_win_adv   (w_win_adv),
    .o_fmap_addr (fmap_addr),
    .o_out_addr  (out_addr),
    .o_last_elem (w_last_elem),
    .o_last_win  (w_last_win)
  );

  // Each output is set on the transition into the state it belongs to, so it is
  // high for exactly that state's cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_mr_clear  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= CLEAR;
            r_busy     <= 1'b1;
            r_mr_clear <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        CLEAR: begin
          r_mr_clear <= 1'b0;
          r_rd_en    <= 1'b1;
          r_state    <= READ;
        end
        READ: begin
          if (w_last_elem) begin
            r_rd_en <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_state <= READ;
          end
        end
        DRAIN: begin
          r_out_valid <= 1'b1;
          r_state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_win) begin
              r_state <= FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= CLEAR;
              r_mr_clear <= 1'b1;
            end
          end else begin
            r_state <= EMIT;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_mr_clear  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // RAM data arrives one cycle after the strobe, so the max_reg qualifier lags by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mr_valid <= 1'b0;
    end else begin
      r_mr_valid <= r_rd_en;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign fmap_rd_en = r_rd_en;
  assign mr_clear   = r_mr_clear;
  assign mr_valid   = r_mr_valid;
  assign mr_din     = fmap_rdata;
  assign out_valid  = r_out_valid;
  assign out_data   = mr_max;

endmodule
